// File: rtl/toplevel_soc_pio_pkg.sv
// Shared constants for the key/switch PIO: register word offsets and edge-mode encodings.
package toplevel_soc_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_DIR     = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE    = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/toplevel_soc_key_irq_if.sv
// Avalon-MM slave signal bundle for the key PIO. The slave samples address/chipselect/write/writedata
// on every clk edge (no wait states, no ready); a write takes effect only when chipselect=1 and write=1.
interface toplevel_soc_key_irq_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write, writedata,
    output readdata
  );

endinterface

// File: rtl/toplevel_soc_key_debounce.sv
// One input bit: two-flop synchroniser followed by a counter debouncer that accepts a new level
// only after DEBOUNCE_CYCLES consecutive cycles of disagreement with the current debounced level.
module toplevel_soc_key_debounce #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RESET_BIT       = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin_i,
  output logic deb_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The >= compare doubles as saturation: the counter can never run past CNT_LAST.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync2_q != deb_q) begin
      if (cnt_q >= CNT_LAST) begin
        deb_d = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= RESET_BIT;
      sync2_q <= RESET_BIT;
      cnt_q   <= '0;
      deb_q   <= RESET_BIT;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/toplevel_soc_key_irq.sv
// Key/switch input PIO: per-bit sync+debounce, edge capture with write-1-to-clear, IRQ mask,
// level IRQ and a registered Avalon-MM read mux at the standard PIO offsets.
module toplevel_soc_key_irq
  import toplevel_soc_pio_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_MODE       = 1,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESET_MASK      = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  toplevel_soc_key_irq_if.slave bus,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq
);

  logic [WIDTH-1:0] deb, deb_prev_q, evt, clr;
  logic [WIDTH-1:0] edge_q, edge_d, mask_q, mask_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             wr_en;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    toplevel_soc_key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_BIT       (RESET_LEVEL[i])
    ) u_deb (
      .clk     (clk),
      .reset_n (reset_n),
      .pin_i   (in_port[i]),
      .deb_o   (deb[i])
    );
  end

  // deb_prev_q resets to the idle level, so leaving reset with pins idle produces no event.
  always_comb begin
    if (EDGE_MODE == EDGE_RISE)      evt = deb & ~deb_prev_q;
    else if (EDGE_MODE == EDGE_FALL) evt = ~deb & deb_prev_q;
    else                             evt = deb ^ deb_prev_q;
  end

  assign wr_en = bus.chipselect & bus.write;

  always_comb begin
    clr    = '0;
    mask_d = mask_q;
    if (wr_en && bus.address == PIO_ADDR_EDGE)    clr    = bus.writedata[WIDTH-1:0];
    if (wr_en && bus.address == PIO_ADDR_IRQMASK) mask_d = bus.writedata[WIDTH-1:0];
    edge_d = evt | (edge_q & ~clr);
  end

  always_comb begin
    rdata_d = '0;
    case (bus.address)
      PIO_ADDR_DATA:    rdata_d[WIDTH-1:0] = deb;
      PIO_ADDR_IRQMASK: rdata_d[WIDTH-1:0] = mask_q;
      PIO_ADDR_EDGE:    rdata_d[WIDTH-1:0] = edge_q;
      default:          rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_prev_q <= RESET_LEVEL;
      edge_q     <= '0;
      mask_q     <= RESET_MASK;
      rdata_q    <= '0;
    end else begin
      deb_prev_q <= deb;
      edge_q     <= edge_d;
      mask_q     <= mask_d;
      rdata_q    <= rdata_d;
    end
  end

  assign bus.readdata = rdata_q;
  assign irq          = |(edge_q & mask_q);

endmodule

// File: tb/tb_toplevel_soc_key_irq.sv
// Directed bench for the key PIO with WIDTH=2, DEBOUNCE_CYCLES=4, falling-edge capture.
module tb_toplevel_soc_key_irq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] in_port;
  logic       irq;
  int         n_vec = 0;
  int         n_err = 0;

  toplevel_soc_key_irq_if bus ();

  toplevel_soc_key_irq #(
    .WIDTH           (2),
    .DEBOUNCE_CYCLES (4),
    .EDGE_MODE       (1),
    .RESET_LEVEL     (2'b11),
    .RESET_MASK      (2'b00)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .in_port (in_port),
    .irq     (irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks: inputs change and outputs are sampled 1 ns after the rising edge
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    bus.address    = addr;
    bus.writedata  = data;
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    tick(1);
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.writedata  = '0;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    bus.address = addr;
    tick(1);
    data = bus.readdata;
  endtask

  logic [31:0] rd;

  initial begin
    reset_n        = 1'b0;
    in_port        = 2'b11;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.writedata  = '0;
    tick(3);
    check("rst_readdata", bus.readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;

    // 1: reset values through the read port
    bus_read(2'd0, rd); check("t1_data", rd, 32'h3);
    bus_read(2'd2, rd); check("t1_mask", rd, 32'h0);
    bus_read(2'd3, rd); check("t1_edge", rd, 32'h0);
    check("t1_irq", {31'b0, irq}, 32'h0);

    // 2: a 3-cycle glitch must be rejected
    in_port = 2'b10;
    tick(3);
    in_port = 2'b11;
    tick(10);
    bus_read(2'd0, rd); check("t2_data", rd, 32'h3);
    bus_read(2'd3, rd); check("t2_edge", rd, 32'h0);

    // 3: held press; debounced changes 6 edges later, seen on readdata one edge after that
    bus.address = 2'd0;
    in_port = 2'b10;
    tick(6);
    check("t3_data_pre", bus.readdata, 32'h3);
    tick(1);
    check("t3_data", bus.readdata, 32'h2);
    bus_read(2'd3, rd); check("t3_edge", rd, 32'h1);
    check("t3_irq_masked", {31'b0, irq}, 32'h0);
    bus_write(2'd2, 32'h1);
    check("t3_irq_on", {31'b0, irq}, 32'h1);

    // 4: write-1-to-clear only affects the written bits
    bus_write(2'd3, 32'h2);
    bus_read(2'd3, rd); check("t4_edge_kept", rd, 32'h1);
    check("t4_irq_kept", {31'b0, irq}, 32'h1);
    bus_write(2'd3, 32'h1);
    check("t4_irq_off", {31'b0, irq}, 32'h0);
    bus_read(2'd3, rd); check("t4_edge_clr", rd, 32'h0);

    // 5: bit-1 event and a clear of bit 1 on the same edge; the event must win
    in_port = 2'b00;
    tick(6);
    bus_write(2'd3, 32'h2);
    bus_read(2'd3, rd); check("t5_edge_set_wins", rd, 32'h2);
    check("t5_irq", {31'b0, irq}, 32'h0);
    bus_read(2'd0, rd); check("t5_data", rd, 32'h0);

    // 6: reset in the middle of a debounce with irq active
    bus_write(2'd2, 32'h3);
    check("t6_irq_pre", {31'b0, irq}, 32'h1);
    in_port = 2'b11;
    tick(10);
    bus_read(2'd0, rd); check("t6_data_idle", rd, 32'h3);
    in_port = 2'b10;
    tick(4);
    reset_n = 1'b0;
    #1;
    check("t6_irq_in_rst", {31'b0, irq}, 32'h0);
    check("t6_rd_in_rst", bus.readdata, 32'h0);
    in_port = 2'b11;
    tick(2);
    reset_n = 1'b1;
    bus.address = 2'd3;
    begin
      int irq_seen = 0;
      for (int i = 0; i < 20; i++) begin
        tick(1);
        if (irq !== 1'b0) irq_seen++;
      end
      check("t6_no_irq_20", irq_seen, 32'h0);
    end
    check("t6_edge", bus.readdata, 32'h0);
    bus_read(2'd0, rd); check("t6_data", rd, 32'h3);
    bus_read(2'd2, rd); check("t6_mask", rd, 32'h0);
    bus_read(2'd1, rd); check("t6_reserved", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
